// File: rtl/rx_pkg.sv
// Shared constants, FSM encoding and byte-count helper for the MAC receive
// frame writer.
package rx_pkg;

  localparam int BUF_AW = 10;

  localparam logic [BUF_AW-1:0] MAX_OCCUPANCY = 10'd511;

  // The frame length lives in the low 16 bits of the header QWORD.
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HDR  = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rx_frame_writer.sv
// Writes MAC receive frames into a 1024x64 ring buffer behind a reserved
// length header, committing only complete good frames that fit.
module rx_frame_writer
  import rx_pkg::BUF_AW, rx_pkg::HDR_LEN_LSB, rx_pkg::HDR_LEN_W, rx_pkg::rx_state_t,
         rx_pkg::ST_IDLE, rx_pkg::ST_RECV, rx_pkg::ST_HDR, rx_pkg::ST_DROP,
         rx_pkg::keep_bytes;
#(
  parameter logic [9:0] MAX_FRAME_QW  = 10'd191,
  parameter logic [9:0] MAX_OCCUPANCY = 10'd511
) (
  input  logic              clk156,
  input  logic              reset,
  input  logic [63:0]       mac_rx_tdata,
  input  logic [7:0]        mac_rx_tkeep,
  input  logic              mac_rx_tvalid,
  input  logic              mac_rx_tlast,
  input  logic              mac_rx_tuser,
  input  logic [BUF_AW-1:0] commited_rd_address,
  output logic              wr_en,
  output logic [BUF_AW-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic [BUF_AW-1:0] commited_wr_address,
  output logic [31:0]       dropped_frames
);

  rx_state_t         state, state_nxt;
  logic [BUF_AW-1:0] hdr_addr, hdr_addr_nxt;
  logic [15:0]       byte_cnt, byte_cnt_nxt;
  logic [9:0]        data_qw, data_qw_nxt;
  logic              wr_en_nxt;
  logic [BUF_AW-1:0] wr_addr_nxt;
  logic [63:0]       wr_data_nxt;
  logic              commit_pend, commit_pend_nxt;
  logic [BUF_AW-1:0] commit_val, commit_val_nxt;
  logic              drop_inc;
  logic [BUF_AW-1:0] base_addr, occupancy, free_qw;
  logic              fits;
  logic [3:0]        beat_bytes;
  logic [63:0]       header;

  // A commit still in flight is forwarded so a frame starting right after a
  // header never reuses a slot that is about to be committed.
  assign base_addr  = commit_pend ? commit_val : commited_wr_address;
  assign occupancy  = base_addr - commited_rd_address;
  assign free_qw    = MAX_OCCUPANCY - occupancy;
  assign fits       = (free_qw >= MAX_FRAME_QW);
  assign beat_bytes = keep_bytes(mac_rx_tkeep);

  always_ff @(posedge clk156) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    hdr_addr_nxt    = hdr_addr;
    byte_cnt_nxt    = byte_cnt;
    data_qw_nxt     = data_qw;
    wr_en_nxt       = 1'b0;
    wr_addr_nxt     = wr_addr;
    wr_data_nxt     = mac_rx_tdata;
    commit_pend_nxt = 1'b0;
    commit_val_nxt  = commit_val;
    drop_inc        = 1'b0;
    header          = '0;
    header[HDR_LEN_LSB +: HDR_LEN_W] = byte_cnt;

    case (state)
      ST_IDLE: begin
        if (mac_rx_tvalid) begin
          if (fits) begin
            hdr_addr_nxt = base_addr;
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = base_addr + 10'd1;
            byte_cnt_nxt = {12'd0, beat_bytes};
            data_qw_nxt  = 10'd1;
            if (!mac_rx_tlast)     state_nxt = ST_RECV;
            else if (mac_rx_tuser) state_nxt = ST_HDR;
            else                   drop_inc  = 1'b1;
          end else if (mac_rx_tlast) begin
            drop_inc = 1'b1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end

      ST_RECV: begin
        if (mac_rx_tvalid) begin
          // One slot of the footprint belongs to the header.
          if (data_qw >= MAX_FRAME_QW - 10'd1) begin
            if (mac_rx_tlast) begin
              drop_inc  = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DROP;
            end
          end else begin
            wr_en_nxt    = 1'b1;
            wr_addr_nxt  = hdr_addr + 10'd1 + data_qw;
            byte_cnt_nxt = byte_cnt + {12'd0, beat_bytes};
            data_qw_nxt  = data_qw + 10'd1;
            if (mac_rx_tlast) begin
              if (mac_rx_tuser) begin
                state_nxt = ST_HDR;
              end else begin
                drop_inc  = 1'b1;
                state_nxt = ST_IDLE;
              end
            end
          end
        end
      end

      ST_HDR: begin
        wr_en_nxt       = 1'b1;
        wr_addr_nxt     = hdr_addr;
        wr_data_nxt     = header;
        commit_pend_nxt = 1'b1;
        commit_val_nxt  = hdr_addr + 10'd1 + data_qw;
        state_nxt       = ST_IDLE;
        // A beat here broke the inter-frame gap, so that new frame is lost.
        if (mac_rx_tvalid) begin
          if (mac_rx_tlast) drop_inc  = 1'b1;
          else              state_nxt = ST_DROP;
        end
      end

      ST_DROP: begin
        if (mac_rx_tvalid && mac_rx_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      hdr_addr            <= '0;
      byte_cnt            <= '0;
      data_qw             <= '0;
      wr_en               <= 1'b0;
      wr_addr             <= '0;
      wr_data             <= '0;
      commit_pend         <= 1'b0;
      commit_val          <= '0;
      commited_wr_address <= '0;
      dropped_frames      <= '0;
    end else begin
      hdr_addr    <= hdr_addr_nxt;
      byte_cnt    <= byte_cnt_nxt;
      data_qw     <= data_qw_nxt;
      wr_en       <= wr_en_nxt;
      wr_addr     <= wr_addr_nxt;
      wr_data     <= wr_data_nxt;
      commit_pend <= commit_pend_nxt;
      commit_val  <= commit_val_nxt;
      if (commit_pend) commited_wr_address <= commit_val;
      if (drop_inc && (dropped_frames != 32'hFFFF_FFFF))
        dropped_frames <= dropped_frames + 32'd1;
    end
  end

endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed bench for rx_frame_writer: frame layout, commit latency, drops,
// truncation, wrap-around and reset behaviour.
module tb_rx_frame_writer;

  logic        clk156 = 1'b0;
  logic        reset;
  logic [63:0] mac_rx_tdata;
  logic [7:0]  mac_rx_tkeep;
  logic        mac_rx_tvalid;
  logic        mac_rx_tlast;
  logic        mac_rx_tuser;
  logic [9:0]  commited_rd_address;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  commited_wr_address;
  logic [31:0] dropped_frames;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;
  logic [63:0] mem [0:1023];

  always #5 clk156 = ~clk156;

  rx_frame_writer dut (
    .clk156              (clk156),
    .reset               (reset),
    .mac_rx_tdata        (mac_rx_tdata),
    .mac_rx_tkeep        (mac_rx_tkeep),
    .mac_rx_tvalid       (mac_rx_tvalid),
    .mac_rx_tlast        (mac_rx_tlast),
    .mac_rx_tuser        (mac_rx_tuser),
    .commited_rd_address (commited_rd_address),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .commited_wr_address (commited_wr_address),
    .dropped_frames      (dropped_frames)
  );

  // Shadow of the buffer, captured mid-cycle from the registered write port.
  always @(negedge clk156) begin
    if (wr_en === 1'b1) begin
      mem[wr_addr] = wr_data;
      wr_count++;
    end
  end

  function automatic logic [63:0] pattern(input int tag, input int idx);
    return {16'hD0D0, 16'(tag), 32'(idx)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk156);
      #1;
    end
  endtask

  task automatic send_frame(input int nbytes, input bit user, input int tag);
    int nbeats;
    int rem;
    nbeats = (nbytes + 7) / 8;
    rem    = nbytes % 8;
    for (int i = 0; i < nbeats; i++) begin
      mac_rx_tvalid = 1'b1;
      mac_rx_tdata  = pattern(tag, i);
      mac_rx_tlast  = (i == nbeats - 1);
      mac_rx_tuser  = (i == nbeats - 1) ? user : 1'b0;
      if (i == nbeats - 1 && rem != 0) mac_rx_tkeep = 8'((1 << rem) - 1);
      else                             mac_rx_tkeep = 8'hFF;
      @(posedge clk156);
      #1;
    end
    mac_rx_tvalid = 1'b0;
    mac_rx_tlast  = 1'b0;
    mac_rx_tuser  = 1'b0;
    mac_rx_tkeep  = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    vectors++;
    if (wr_en !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wr_en);
    end
    vectors++;
    if (wr_addr !== 10'd0) begin
      miscompares++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", wr_addr);
    end
    vectors++;
    if (wr_data !== 64'd0) begin
      miscompares++; $display("[TB] FAIL reset_wr_data: got %h expected 0", wr_data);
    end
    vectors++;
    if (commited_wr_address !== 10'd0) begin
      miscompares++; $display("[TB] FAIL reset_commit: got %0d expected 0", commited_wr_address);
    end
    vectors++;
    if (dropped_frames !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_dropped: got %0d expected 0", dropped_frames);
    end
  endtask

  task automatic test_good_64();
    int w0;
    w0 = wr_count;
    send_frame(64, 1'b1, 1);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd8 || wr_data !== pattern(1, 7)) begin
      miscompares++;
      $display("[TB] FAIL g64_last_write: got en=%b addr=%0d data=%h expected en=1 addr=8 data=%h",
               wr_en, wr_addr, wr_data, pattern(1, 7));
    end
    idle(1);
    vectors++;
    if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 64'h40) begin
      miscompares++;
      $display("[TB] FAIL g64_header_write: got en=%b addr=%0d data=%h expected en=1 addr=0 data=40",
               wr_en, wr_addr, wr_data);
    end
    vectors++;
    if (commited_wr_address !== 10'd0) begin
      miscompares++; $display("[TB] FAIL g64_commit_early: got %0d expected 0", commited_wr_address);
    end
    idle(1);
    vectors++;
    if (commited_wr_address !== 10'd9) begin
      miscompares++; $display("[TB] FAIL g64_commit: got %0d expected 9", commited_wr_address);
    end
    idle(1);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[i + 1] !== pattern(1, i)) begin
        miscompares++;
        $display("[TB] FAIL g64_data[%0d]: got %h expected %h", i + 1, mem[i + 1], pattern(1, i));
      end
    end
    vectors++;
    if (wr_count - w0 !== 9) begin
      miscompares++; $display("[TB] FAIL g64_write_count: got %0d expected 9", wr_count - w0);
    end
  endtask

  task automatic test_good_61();
    int w0;
    w0 = wr_count;
    send_frame(61, 1'b1, 2);
    idle(3);
    vectors++;
    if (mem[9] !== 64'd61) begin
      miscompares++; $display("[TB] FAIL g61_header: got %h expected 3d", mem[9]);
    end
    vectors++;
    if (mem[17] !== pattern(2, 7)) begin
      miscompares++; $display("[TB] FAIL g61_last_data: got %h expected %h", mem[17], pattern(2, 7));
    end
    vectors++;
    if (commited_wr_address !== 10'd18) begin
      miscompares++; $display("[TB] FAIL g61_commit: got %0d expected 18", commited_wr_address);
    end
    vectors++;
    if (wr_count - w0 !== 9) begin
      miscompares++; $display("[TB] FAIL g61_write_count: got %0d expected 9", wr_count - w0);
    end
  endtask

  task automatic test_bad_frame();
    send_frame(24, 1'b0, 3);
    idle(4);
    vectors++;
    if (commited_wr_address !== 10'd18) begin
      miscompares++; $display("[TB] FAIL bad_commit: got %0d expected 18", commited_wr_address);
    end
    vectors++;
    if (dropped_frames !== 32'd1) begin
      miscompares++; $display("[TB] FAIL bad_dropped: got %0d expected 1", dropped_frames);
    end
    send_frame(16, 1'b1, 4);
    idle(3);
    vectors++;
    if (mem[18] !== 64'd16) begin
      miscompares++; $display("[TB] FAIL bad_reuse_header: got %h expected 10", mem[18]);
    end
    vectors++;
    if (commited_wr_address !== 10'd21) begin
      miscompares++; $display("[TB] FAIL bad_reuse_commit: got %0d expected 21", commited_wr_address);
    end
  endtask

  task automatic test_full();
    int w0;
    commited_rd_address = 10'd645;
    w0 = wr_count;
    send_frame(32, 1'b1, 5);
    idle(3);
    vectors++;
    if (wr_count - w0 !== 0) begin
      miscompares++; $display("[TB] FAIL full_writes: got %0d expected 0", wr_count - w0);
    end
    vectors++;
    if (dropped_frames !== 32'd2) begin
      miscompares++; $display("[TB] FAIL full_dropped: got %0d expected 2", dropped_frames);
    end
    commited_rd_address = 10'd745;
    send_frame(32, 1'b1, 6);
    idle(3);
    vectors++;
    if (mem[21] !== 64'd32) begin
      miscompares++; $display("[TB] FAIL full_retry_header: got %h expected 20", mem[21]);
    end
    vectors++;
    if (commited_wr_address !== 10'd26) begin
      miscompares++; $display("[TB] FAIL full_retry_commit: got %0d expected 26", commited_wr_address);
    end
  endtask

  task automatic test_oversize();
    int w0;
    commited_rd_address = 10'd26;
    w0 = wr_count;
    send_frame(2000, 1'b1, 7);
    idle(3);
    vectors++;
    if (wr_count - w0 !== 190) begin
      miscompares++; $display("[TB] FAIL over_writes: got %0d expected 190", wr_count - w0);
    end
    vectors++;
    if (mem[216] !== pattern(7, 189)) begin
      miscompares++; $display("[TB] FAIL over_last_data: got %h expected %h", mem[216], pattern(7, 189));
    end
    vectors++;
    if (dropped_frames !== 32'd3 || commited_wr_address !== 10'd26) begin
      miscompares++;
      $display("[TB] FAIL over_drop: got dropped=%0d commit=%0d expected dropped=3 commit=26",
               dropped_frames, commited_wr_address);
    end
    send_frame(64, 1'b1, 8);
    idle(1);
    send_frame(64, 1'b1, 9);
    idle(3);
    vectors++;
    if (mem[26] !== 64'h40 || mem[27] !== pattern(8, 0)) begin
      miscompares++;
      $display("[TB] FAIL over_next_frame: got hdr=%h d0=%h expected hdr=40 d0=%h",
               mem[26], mem[27], pattern(8, 0));
    end
    vectors++;
    if (mem[35] !== 64'h40 || commited_wr_address !== 10'd44) begin
      miscompares++;
      $display("[TB] FAIL over_following_frame: got hdr=%h commit=%0d expected hdr=40 commit=44",
               mem[35], commited_wr_address);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(16, 1'b1, 10);
    idle(1);
    send_frame(8, 1'b1, 11);
    idle(4);
    vectors++;
    if (mem[44] !== 64'd16) begin
      miscompares++; $display("[TB] FAIL b2b_first_header: got %h expected 10", mem[44]);
    end
    vectors++;
    if (mem[47] !== 64'd8 || mem[48] !== pattern(11, 0)) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_slot: got hdr=%h d0=%h expected hdr=8 d0=%h",
               mem[47], mem[48], pattern(11, 0));
    end
    vectors++;
    if (commited_wr_address !== 10'd49) begin
      miscompares++; $display("[TB] FAIL b2b_commit: got %0d expected 49", commited_wr_address);
    end
  endtask

  task automatic test_gap_violation();
    int w0;
    w0 = wr_count;
    send_frame(8, 1'b1, 12);
    send_frame(16, 1'b1, 13);
    idle(4);
    vectors++;
    if (wr_count - w0 !== 2 || mem[49] !== 64'd8) begin
      miscompares++;
      $display("[TB] FAIL gap_writes: got count=%0d hdr=%h expected count=2 hdr=8",
               wr_count - w0, mem[49]);
    end
    vectors++;
    if (commited_wr_address !== 10'd51 || dropped_frames !== 32'd4) begin
      miscompares++;
      $display("[TB] FAIL gap_state: got commit=%0d dropped=%0d expected commit=51 dropped=4",
               commited_wr_address, dropped_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) begin
      mac_rx_tvalid = 1'b1;
      mac_rx_tkeep  = 8'hFF;
      mac_rx_tdata  = pattern(14, i);
      @(posedge clk156);
      #1;
    end
    mac_rx_tvalid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(4);
    vectors++;
    if (commited_wr_address !== 10'd0 || dropped_frames !== 32'd0 || wr_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: got commit=%0d dropped=%0d en=%b expected 0 0 0",
               commited_wr_address, dropped_frames, wr_en);
    end
  endtask

  task automatic test_wrap();
    int exp_commit;
    exp_commit = 0;
    for (int k = 0; k < 5; k++) begin
      commited_rd_address = 10'(exp_commit);
      send_frame(1520, 1'b1, 20 + k);
      idle(3);
      exp_commit += 191;
    end
    vectors++;
    if (commited_wr_address !== 10'd955) begin
      miscompares++; $display("[TB] FAIL wrap_max_frames: got %0d expected 955", commited_wr_address);
    end
    commited_rd_address = 10'd955;
    send_frame(512, 1'b1, 30);
    idle(3);
    vectors++;
    if (commited_wr_address !== 10'd1020) begin
      miscompares++; $display("[TB] FAIL wrap_prefill: got %0d expected 1020", commited_wr_address);
    end
    commited_rd_address = 10'd1000;
    send_frame(64, 1'b1, 31);
    idle(3);
    vectors++;
    if (mem[1020] !== 64'h40) begin
      miscompares++; $display("[TB] FAIL wrap_header: got %h expected 40", mem[1020]);
    end
    vectors++;
    if (mem[1021] !== pattern(31, 0) || mem[1023] !== pattern(31, 2)) begin
      miscompares++;
      $display("[TB] FAIL wrap_data_top: got %h %h expected %h %h",
               mem[1021], mem[1023], pattern(31, 0), pattern(31, 2));
    end
    vectors++;
    if (mem[0] !== pattern(31, 3) || mem[4] !== pattern(31, 7)) begin
      miscompares++;
      $display("[TB] FAIL wrap_data_low: got %h %h expected %h %h",
               mem[0], mem[4], pattern(31, 3), pattern(31, 7));
    end
    vectors++;
    if (commited_wr_address !== 10'd5) begin
      miscompares++; $display("[TB] FAIL wrap_commit: got %0d expected 5", commited_wr_address);
    end
  endtask

  initial begin
    reset               = 1'b1;
    mac_rx_tdata        = '0;
    mac_rx_tkeep        = '0;
    mac_rx_tvalid       = 1'b0;
    mac_rx_tlast        = 1'b0;
    mac_rx_tuser        = 1'b0;
    commited_rd_address = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    #1;
    test_reset();
    test_good_64();
    test_good_61();
    test_bad_frame();
    test_full();
    test_oversize();
    test_back_to_back();
    test_gap_violation();
    test_reset_mid_frame();
    commited_rd_address = '0;
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_frame_writer.md
RX_FRAME_WRITER -- requirements
Module: rx_frame_writer

Interface
REQ-001 SHALL have parameter MAX_FRAME_QW, default 10'd191, the largest frame footprint in QWORDs (header plus 1518-byte payload).
REQ-002 SHALL have parameter MAX_OCCUPANCY, default 10'd511, the largest buffer occupancy the downstream trigger can represent (9-bit difference).
REQ-003 clk156  in  1  the 156.25 MHz clock; the only clock in the block.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mac_rx_tdata  in  64  MAC receive beat; byte 0 is in bits [7:0].
REQ-006 mac_rx_tkeep  in  8  byte enables; 8'hFF on every non-last beat; contiguous from bit 0 on the last beat.
REQ-007 mac_rx_tvalid  in  1  beat valid; there is no backpressure.
REQ-008 mac_rx_tlast  in  1  last beat of the frame.
REQ-009 mac_rx_tuser  in  1  sampled with tlast: 1 = good frame, 0 = bad frame (FCS or other error).
REQ-010 commited_rd_address  in  10  consumer read pointer, already synchronous to clk156.
REQ-011 wr_en  out  1  write strobe to the 1024x64 internal buffer.
REQ-012 wr_addr  out  10  buffer write address.
REQ-013 wr_data  out  64  buffer write data.
REQ-014 commited_wr_address  out  10  first free QWORD after the last committed good frame.
REQ-015 dropped_frames  out  32  saturating count of frames not committed.

Function
REQ-016 wr_en, wr_addr and wr_data SHALL be registered; a beat accepted in cycle T appears on the write port in cycle T+1.
REQ-017 All address arithmetic SHALL be modulo 1024; occupancy = commited_wr_address - commited_rd_address; free = MAX_OCCUPANCY - occupancy.
REQ-018 The FSM SHALL have four states: IDLE, RECV, HDR and DROP; any other encoding SHALL return to IDLE.
REQ-019 In IDLE, when tvalid is high and free >= MAX_FRAME_QW, the block SHALL:
  - reserve the header slot H = commited_wr_address;
  - write the beat to H+1;
  - set the byte count to 8 and go to RECV.
REQ-020 In IDLE, when tvalid is high and free < MAX_FRAME_QW, the block SHALL go to DROP and write nothing.
REQ-021 In IDLE, when a single-beat frame (tvalid with tlast) fits, it SHALL be written and the block SHALL go straight to HDR (good) or IDLE plus drop (bad).
REQ-022 In RECV, each valid beat SHALL be written to the next address and the byte count SHALL grow by popcount(tkeep).
REQ-023 In RECV, a tlast beat with tuser=1 SHALL lead to HDR; a tlast beat with tuser=0 SHALL return to IDLE, leave commited_wr_address unchanged and increment dropped_frames.
REQ-024 In RECV, when a beat would exceed MAX_FRAME_QW-1 data QWORDs, it SHALL NOT be written and the block SHALL go to DROP (truncation); if that beat also carries tlast, the frame SHALL be counted as dropped and the block SHALL return to IDLE.
REQ-025 In DROP, the block SHALL ignore beats until tlast, then increment dropped_frames and go to IDLE.
REQ-026 In HDR, the block SHALL write wr_data = {48'b0, byte_count[15:0]} to H.
REQ-027 On the edge after the header appears on the write port, commited_wr_address SHALL become H+1+data_qwords.
  - Latency: tlast in cycle T, data write in T+1, header write in T+2, commit visible in T+3.
REQ-028 A tvalid beat arriving while in HDR (inter-frame gap violation) SHALL make that frame dropped: the block goes to DROP, or counts the drop immediately if the beat carries tlast.
REQ-029 tvalid low in RECV SHALL hold state; idle cycles inside a frame are legal.
REQ-030 dropped_frames SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-031 Reset SHALL set the FSM to IDLE and clear wr_en, wr_addr, wr_data, commited_wr_address, dropped_frames, the byte count and H to zero.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame without committing it or counting it.
REQ-033 Beats still arriving after reset is released SHALL be treated as a new frame start, a known hazard accepted by the team.

Structure
REQ-034 A shared package rx_pkg SHALL hold BUF_AW=10, MAX_OCCUPANCY, the header length-field position, the FSM state encodings and a tkeep-to-byte-count function.
REQ-035 The block SHALL be a single flat module with no sub-module.

Verification
REQ-036 Reset, then a good 64-byte frame (8 beats, last tkeep=8'hFF):
  - data written to addresses 1..8;
  - header 64'h40 written to address 0;
  - commited_wr_address becomes 9 three cycles after tlast.
REQ-037 Good 61-byte frame with last tkeep=8'h1F: header length = 16'd61; data QWORDs = 8.
REQ-038 Bad frame (tuser=0 at tlast): commited_wr_address unchanged, dropped_frames +1, the next good frame reuses the same header slot.
REQ-039 Wrap-around: commited_wr_address=1020, commited_rd_address=1000, good 64-byte frame:
  - header at 1020;
  - data at 1021..1023 and 0..4;
  - commit = 5.
REQ-040 Full: occupancy 400 (free 111 < 191), frame arrives -> no writes, dropped_frames +1; raise commited_rd_address by 100 and the next frame is accepted.
REQ-041 Oversize 2000-byte frame:
  - 190 data QWORDs written, then DROP;
  - no commit, dropped_frames +1;
  - a back-to-back frame after a one-cycle gap is accepted normally.
